// File: rtl/gpmc_bram_capture_writer.sv
// gpmc_bram_capture_writer: streams valid/ready samples into BRAM port B from address 0, one-shot or ring (CAPTURE_WRAP_EN).
module gpmc_bram_capture_writer #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int CAP_LEN = 2048
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              arm,
  input  logic              stop,
  output logic              b_ena,
  output logic              b_wr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              wrapped
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0] count_nxt;
  logic accept, start, last, wrap_nxt;
  assign s_ready = state == CAPTURE;
  assign busy = s_ready;
  assign done = state == DONE;
  assign b_wr = b_ena;
  assign accept = s_valid && s_ready;
  assign start = arm && state != CAPTURE;
`ifdef CAPTURE_WRAP_EN
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  assign count_nxt = word_count == DEPTH ? word_count : word_count + 1'b1;
  assign last = 1'b0;
  // a write landing on address 0 after at least one word means the ring has wrapped
  assign wrap_nxt = wrapped || (wr_ptr == '0 && word_count != '0);
`else
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(CAP_LEN);
  assign count_nxt = word_count + 1'b1;
  assign last = accept && count_nxt == CAP;
  assign wrap_nxt = 1'b0;
`endif
  always_comb begin
    state_nxt = start ? CAPTURE : (s_ready && (stop || last)) ? DONE : state;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      b_ena <= 1'b0;
      b_addr <= '0;
      b_din <= '0;
      wr_ptr <= '0;
      word_count <= '0;
      wrapped <= 1'b0;
    end else begin
      state <= state_nxt;
      b_ena <= accept;
      if (start) begin
        wr_ptr <= '0;
        word_count <= '0;
        wrapped <= 1'b0;
      end else if (accept) begin
        b_addr <= wr_ptr;
        b_din <= s_data;
        wr_ptr <= wr_ptr + 1'b1;
        word_count <= count_nxt;
        wrapped <= wrap_nxt;
      end
    end
  end
endmodule

// File: tb/tb_gpmc_bram_capture_writer.sv
// tb_gpmc_bram_capture_writer: directed and random stimulus against a count/queue level capture model.
module tb_gpmc_bram_capture_writer;
  localparam int AW = 3, DW = 16, CAP = 4, DEPTH = 8;
`ifdef CAPTURE_WRAP_EN
  localparam bit RING = 1'b1;
`else
  localparam bit RING = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1, s_valid = 1'b0, arm = 1'b0, stop = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, b_ena, b_wr, busy, done, wrapped;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din;
  logic [AW:0] word_count;
  int total = 0, bad = 0;
  bit m_cap, m_done, m_ena, m_wrap;
  int m_n, m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] obs_mem [DEPTH];

  always #5 CLK = ~CLK;

  gpmc_bram_capture_writer #(.ADDR_W(AW), .DATA_W(DW), .CAP_LEN(CAP)) dut (
    .CLK(CLK), .RST(RST), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .arm(arm), .stop(stop), .b_ena(b_ena), .b_wr(b_wr), .b_addr(b_addr),
    .b_din(b_din), .busy(busy), .done(done), .word_count(word_count), .wrapped(wrapped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_done = 0; m_ena = 0; m_wrap = 0; m_n = 0; m_addr = 0; m_din = '0;
  endtask

  // accepted samples land at (index mod depth); the capture ends on stop or at CAP words
  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit a, input bit s);
    bit acc = m_cap && v;
    m_ena = acc;
    if (acc) begin
      m_addr = m_n % DEPTH;
      m_din = d;
      exp_mem[m_n % DEPTH] = d;
      m_n++;
      if (RING && m_n > DEPTH) m_wrap = 1;
    end
    if (m_cap) begin
      if (s || (!RING && m_n == CAP)) begin m_cap = 0; m_done = 1; end
    end else if (a) begin
      m_cap = 1; m_done = 0; m_n = 0; m_wrap = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    int wc = (RING && m_n > DEPTH) ? DEPTH : m_n;
    check({tag, ".b_ena"}, b_ena, m_ena);
    check({tag, ".b_wr"}, b_wr, m_ena);
    check({tag, ".b_addr"}, b_addr, m_addr);
    check({tag, ".b_din"}, b_din, m_din);
    check({tag, ".busy"}, busy, m_cap);
    check({tag, ".s_ready"}, s_ready, m_cap);
    check({tag, ".done"}, done, m_done);
    check({tag, ".word_count"}, word_count, wc);
    check({tag, ".wrapped"}, wrapped, m_wrap);
  endtask

  task automatic cyc(input string tag, input bit v, input logic [DW-1:0] d, input bit a, input bit s);
    s_valid = v; s_data = d; arm = a; stop = s;
    @(posedge CLK);
    #1;
    if (RST) model_reset(); else model_step(v, d, a, s);
    if (b_ena && b_wr) obs_mem[b_addr] = b_din;
    compare_all(tag);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) check($sformatf("%s.mem%0d", tag, i), obs_mem[i], exp_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = '0; obs_mem[i] = '0; end
    model_reset();
    #12 RST = 1'b0;
    compare_all("reset");
    // asynchronous reset in the middle of a burst
    cyc("t1_arm", 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("t1_burst", 1, DW'(16'h1000 + i), 0, 0);
    #2 RST = 1'b1;
    #1 model_reset();
    compare_all("t1_async");
    for (int i = 0; i < 3; i++) cyc("t1_held", 1, DW'(16'h1100 + i), 1, 0);
    #2 RST = 1'b0;
    cyc("t1_idle", 1, 16'h1200, 0, 0);
    // continuous stream past the capture length
    cyc("t2_arm", 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cyc("t2_stream", 1, DW'(16'hA000 + i), 0, 0);
`ifndef CAPTURE_WRAP_EN
      if (i == 3) check("t2_ready_after_4th", s_ready, 0);
`endif
    end
    cyc("t2_tail", 0, '0, 0, 0);
`ifndef CAPTURE_WRAP_EN
    check("t2_done", done, 1);
    check("t2_count", word_count, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_mem%0d", i), obs_mem[i], 32'hA000 + i);
`endif
    cyc("t2_stop", 0, '0, 0, 1);
    // early stop coinciding with the third accept
    cyc("t3_arm", 0, '0, 1, 0);
    cyc("t3_w0", 1, 16'hB000, 0, 0);
    cyc("t3_w1", 1, 16'hB001, 0, 0);
    cyc("t3_w2", 1, 16'hB002, 0, 1);
    cyc("t3_tail", 1, 16'hB003, 0, 0);
    check("t3_count", word_count, 3);
    check("t3_done", done, 1);
    for (int i = 0; i < 3; i++) check($sformatf("t3_mem%0d", i), obs_mem[i], 32'hB000 + i);
    // gapped input, then arm+stop together while done
    cyc("t4_arm", 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) cyc("t4_gap", !i[0], DW'(16'hC000 + i), 0, 0);
    check("t4_count", word_count, 3);
    cyc("t4_stop", 0, '0, 0, 1);
    cyc("t4_armstop", 0, '0, 1, 1);
    check("t4_rearm_done", done, 0);
    check("t4_rearm_busy", busy, 1);
    check("t4_rearm_count", word_count, 0);
    cyc("t4_first", 1, 16'hD000, 0, 0);
    check("t4_first_addr", b_addr, 0);
    check("t4_first_din", b_din, 32'hD000);
    cyc("t4_end", 0, '0, 0, 1);
    // ten samples into an eight-word buffer
    cyc("t5_arm", 0, '0, 1, 0);
    for (int i = 0; i < 10; i++) cyc("t5_stream", 1, DW'(i), 0, 0);
    cyc("t5_stop", 0, '0, 0, 1);
`ifdef CAPTURE_WRAP_EN
    check("t5_wrapped", wrapped, 1);
    check("t5_count", word_count, 8);
    check("t5_last_addr", b_addr, 1);
    check("t5_mem0", obs_mem[0], 8);
    check("t5_mem1", obs_mem[1], 9);
    for (int i = 2; i < 8; i++) check($sformatf("t5_mem%0d", i), obs_mem[i], i);
`else
    check("t5_wrapped", wrapped, 0);
    check("t5_count", word_count, 4);
`endif
    check_mem("directed");
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    check_mem("random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
